// File: rtl/sync_cnt4.sv
// rtl/sync_cnt4.sv - synchronous presettable binary counter with ripple-carry out
//
// Purpose
//   A WIDTH-bit synchronous counter with clear, parallel load, dual count
//   enables (EP, ET) and a combinational ripple-carry output (RCO). Stages
//   cascade by driving the ET input of stage k+1 from the RCO of stage k,
//   with a shared clock and EP.
//
// Configuration
//   SYNC_CNT4_UPDN_EN : when defined, adds the Up port.
//                       Up=1 counts up, and RCO flags all-ones.
//                       Up=0 counts down, and RCO flags zero.
//                       When undefined, the counter only counts up.
//
// Ports
//   Cp    in   1      clock; all state changes on the rising edge
//   Rn    in   1      synchronous clear, active-low (highest priority)
//   Ld_n  in   1      synchronous parallel load, active-low
//   EP    in   1      count enable P (count only)
//   ET    in   1      count enable T (count and RCO gating / cascade input)
//   Up    in   1      count direction (SYNC_CNT4_UPDN_EN builds only)
//   D     in   WIDTH  parallel load data
//   Q     out  WIDTH  registered count value
//   RCO   out  1      ripple-carry out = ET & terminal count

module sync_cnt4 #(
    parameter int WIDTH = 4
) (
    input  logic             Cp,
    input  logic             Rn,
    input  logic             Ld_n,
    input  logic             EP,
    input  logic             ET,
`ifdef SYNC_CNT4_UPDN_EN
    input  logic             Up,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    // One action per edge. Clear beats load, load beats count, and count beats hold.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_CLEAR = 2'd3
    } action_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    action_e          act;
    logic             up_w;
    logic             terminal_w;
    logic [WIDTH-1:0] step_w;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Direction is a constant 1 in the up-only build, so the down path folds away.
`ifdef SYNC_CNT4_UPDN_EN
    assign up_w = Up;
`else
    assign up_w = 1'b1;
`endif

    // Both directions wrap naturally modulo 2^WIDTH.
    assign step_w = up_w ? (q_q + ONE) : (q_q - ONE);

    // The terminal count is all-ones when counting up and zero when counting down.
    assign terminal_w = up_w ? (q_q == {WIDTH{1'b1}}) : (q_q == {WIDTH{1'b0}});

    always_comb begin
        act = ACT_HOLD;
        if (!Rn) begin
            act = ACT_CLEAR;
        end else if (!Ld_n) begin
            act = ACT_LOAD;
        end else if (EP && ET) begin
            act = ACT_COUNT;
        end
    end

    always_comb begin
        q_d = q_q;
        case (act)
            ACT_CLEAR: q_d = {WIDTH{1'b0}};
            ACT_LOAD:  q_d = D;
            ACT_COUNT: q_d = step_w;
            ACT_HOLD:  q_d = q_q;
            default:   q_d = q_q;
        endcase
    end

    // Rn is folded into q_d, so the clear is sampled only at the edge.
    always_ff @(posedge Cp) begin
        q_q <= q_d;
    end

    assign Q = q_q;

    // EP is deliberately absent from RCO. Only registered Q, ET and direction
    // drive it, so that a cascade's carry never glitches on EP.
    assign RCO = ET & terminal_w;

endmodule

// File: tb/tb_sync_cnt4.sv
// tb/tb_sync_cnt4.sv - scoreboard bench for sync_cnt4 (single stage and 8-bit cascade)

module tb_sync_cnt4;

    logic       Cp = 1'b0;
    logic       Rn, Ld_n, EP, ET;
    logic [3:0] D;
    logic [3:0] Q;
    logic       RCO;

    logic       c_rn, c_ep, c_et;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco;
    logic [3:0] c_d = 4'h0;

`ifdef SYNC_CNT4_UPDN_EN
    logic       Up = 1'b1;
`endif

    always #50 Cp = ~Cp;

    sync_cnt4 #(.WIDTH(4)) dut (
        .Cp(Cp), .Rn(Rn), .Ld_n(Ld_n), .EP(EP), .ET(ET),
`ifdef SYNC_CNT4_UPDN_EN
        .Up(Up),
`endif
        .D(D), .Q(Q), .RCO(RCO)
    );

    sync_cnt4 #(.WIDTH(4)) u_lo (
        .Cp(Cp), .Rn(c_rn), .Ld_n(1'b1), .EP(c_ep), .ET(c_et),
`ifdef SYNC_CNT4_UPDN_EN
        .Up(1'b1),
`endif
        .D(c_d), .Q(lo_q), .RCO(lo_rco)
    );

    sync_cnt4 #(.WIDTH(4)) u_hi (
        .Cp(Cp), .Rn(c_rn), .Ld_n(1'b1), .EP(c_ep), .ET(lo_rco),
`ifdef SYNC_CNT4_UPDN_EN
        .Up(1'b1),
`endif
        .D(c_d), .Q(hi_q), .RCO(hi_rco)
    );

    typedef struct {
        bit         cas;
        logic [7:0] q;
        logic       rco;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: every cycle, after the edge has settled, compare one pending expectation.
    always @(posedge Cp) begin
        #5;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] aq;
            logic       ar;
            e = exp_q.pop_front();
            if (e.cas) begin
                aq = {hi_q, lo_q};
                ar = hi_rco;
            end else begin
                aq = {4'h0, Q};
                ar = RCO;
            end
            n_vec++;
            if (aq !== e.q || ar !== e.rco) begin
                n_fail++;
                $display("FAIL %s: got Q=%0d RCO=%b, expected Q=%0d RCO=%b",
                         e.nm, aq, ar, e.q, e.rco);
            end
        end
    end

    // Drive the inputs for the next edge, then queue what that edge must produce.
    task automatic drive(input logic rn, input logic ld, input logic ep, input logic et,
                         input logic [3:0] d, input logic [3:0] eq, input logic er,
                         input string nm);
        exp_t e;
        Rn = rn; Ld_n = ld; EP = ep; ET = et; D = d;
        e.cas = 1'b0; e.q = {4'h0, eq}; e.rco = er; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge Cp);
        #10;
    endtask

    task automatic vec(input logic rn, input logic ld, input logic ep, input logic et,
                       input logic [3:0] d, input logic [3:0] eq, input logic er,
                       input string nm);
        drive(rn, ld, ep, et, d, eq, er, nm);
        step();
    endtask

    task automatic cvec(input logic rn, input logic [7:0] eq, input logic er, input string nm);
        exp_t e;
        c_rn = rn; c_ep = 1'b1; c_et = 1'b1;
        e.cas = 1'b1; e.q = eq; e.rco = er; e.nm = nm;
        exp_q.push_back(e);
        step();
    endtask

    initial begin
        Rn = 1'b0; Ld_n = 1'b1; EP = 1'b0; ET = 1'b0; D = 4'h0;
        c_rn = 1'b0; c_ep = 1'b0; c_et = 1'b0;
        step();

        // Clear beats a coincident load and count.
        vec(1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 4'd0, 1'b0, "reset_over_load");

        // Seventeen counts from 0: 1..15, then 0, then 1. RCO is high only at 15.
        for (int i = 1; i <= 17; i++) begin
            logic [3:0] eq;
            eq = 4'(i);
            vec(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, eq, (eq == 4'hF), "count_up");
        end

        // Load 14, then count through the wrap.
        vec(1'b1, 1'b0, 1'b1, 1'b1, 4'hE, 4'd14, 1'b0, "load_E");
        vec(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd15, 1'b1, "load_E_cnt15");
        vec(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd0,  1'b0, "load_E_wrap");

        // Hold paths at 7.
        vec(1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 4'd7, 1'b0, "load_7_no_enables");
        for (int i = 0; i < 3; i++)
            vec(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'd7, 1'b0, "hold_ep0");
        vec(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'd7, 1'b0, "hold_et0");

        // At 15, ET gates RCO and EP does not.
        vec(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'd15, 1'b0, "q15_et0_rco0");
        vec(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'd15, 1'b1, "q15_ep0_rco1");

        // Clear on the wrap edge, then release: the release alone leaves Q alone.
        vec(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'd0, 1'b0, "reset_on_wrap");
        vec(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'd0, 1'b0, "release_hold");
        vec(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd1, 1'b0, "resume_from_0");

        // A load pulse between edges has no effect.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 4'd1, 1'b0, "between_edge_pulse");
        #20 Ld_n = 1'b0;
        #20 Ld_n = 1'b1;
        step();

        // Clear beats a load, and a load happens even with both enables low.
        vec(1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'd0, 1'b0, "reset_over_load2");
        vec(1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 4'd5, 1'b0, "load_5");

`ifdef SYNC_CNT4_UPDN_EN
        // Count down from 1 with a wrap, then reverse direction.
        vec(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 4'd1, 1'b0, "dn_load_1");
        Up = 1'b0;
        vec(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd0,  1'b1, "dn_to_0");
        vec(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd15, 1'b0, "dn_wrap_15");
        vec(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd14, 1'b0, "dn_14");
        Up = 1'b1;
        vec(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd15, 1'b1, "up_again_15");
`endif

        // Eight-bit cascade: clear, then 256 counts that wrap 255 to 0 exactly once.
        Ld_n = 1'b1; EP = 1'b0; ET = 1'b0;
        cvec(1'b0, 8'd0, 1'b0, "cas_reset");
        for (int i = 1; i <= 256; i++) begin
            logic [7:0] eq;
            eq = 8'(i);
            cvec(1'b1, eq, (eq == 8'hFF), "cas_count");
        end
        c_ep = 1'b0;

        // Let the monitor drain. Anything left over counts as a miss.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_cnt4.md
SYNC_CNT4 -- requirements
Module: sync_cnt4

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 Port: Cp  input  1  clock; all state changes on rising edge only.
REQ-003 Port: Rn  input  1  reset; synchronous, active-low.
REQ-004 Port: Ld_n  input  1  synchronous parallel-load strobe, active-low.
REQ-005 Port: EP  input  1  count enable P (count only, no effect on RCO).
REQ-006 Port: ET  input  1  count enable T (count and RCO gating, cascade input).
REQ-007 Port: D  input  WIDTH  parallel load data.
REQ-008 Port: Q  output  WIDTH  registered count value.
REQ-009 Port: RCO  output  1  ripple-carry out, combinational from Q, ET and direction.

Function
REQ-010 Each rising Cp edge SHALL apply exactly one action, priority: Rn=0 clear > Ld_n=0 load > (EP&ET)=1 count > hold.
REQ-011 Clear SHALL set Q to 0 at the edge, regardless of Ld_n, EP, ET and D.
REQ-012 Load SHALL set Q to D at the edge, regardless of EP and ET.
REQ-013 Count up SHALL set Q to Q+1 modulo 2^WIDTH; all-ones wraps to 0 in one edge, no extra cycle.
REQ-014 Hold (EP=0 or ET=0, Rn=1, Ld_n=1) SHALL leave Q unchanged.
REQ-015 Q SHALL change only at a rising Cp edge; inputs changing between edges have no effect until the next edge.
REQ-016 Latency: an action selected at edge N SHALL be visible on Q immediately after edge N (one-edge latency, no pipeline).
REQ-017 Up-count RCO SHALL be 1 iff ET=1 and Q equals all-ones; EP SHALL NOT affect RCO.
REQ-018 RCO SHALL be glitch-free with respect to EP changes and SHALL track ET combinationally within the same cycle.
REQ-019 Cascading: RCO of stage k driving ET of stage k+1, shared Cp/EP, SHALL form a synchronous 2*WIDTH-bit counter without extra delay.
REQ-020 Rn asserted mid-count or coincident with a load or wrap SHALL yield Q=0 after that edge; next action resumes from 0.

Reset
REQ-021 Reset is synchronous and active-low: Rn=0 sampled at a rising Cp edge clears; Rn has no effect between edges.
REQ-022 Reset values: Q=0; RCO=0 in up mode (follows REQ-017 from Q=0).
REQ-023 Before the first Rn=0 edge Q is unspecified; benches SHALL apply Rn=0 for at least one edge.
REQ-024 Releasing Rn SHALL NOT by itself change Q; counting resumes at the first edge with Rn=1 and EP&ET=1.

Configuration
REQ-025 Macro SYNC_CNT4_UPDN_EN defined: extra port Up  input  1  direction, 1=up, 0=down.
REQ-026 With SYNC_CNT4_UPDN_EN, Up=0 count SHALL set Q to Q-1 modulo 2^WIDTH (0 wraps to all-ones), RCO SHALL be 1 iff ET=1 and Q=0.
REQ-027 With SYNC_CNT4_UPDN_EN, Up changing with EP&ET=1 SHALL take effect at the next edge; RCO tracks Up combinationally.
REQ-028 Without SYNC_CNT4_UPDN_EN: port Up absent, count up only, behaviour exactly REQ-013/REQ-017.
REQ-029 Clear, load, hold and priority SHALL be identical in both builds.

Verification (WIDTH=4, Cp period 100 ns)
REQ-030 Rn=0 one edge with Ld_n=0, D=4'hA, EP=ET=1 -> Q=0, RCO=0.
REQ-031 Rn=1, Ld_n=1, EP=ET=1, 17 edges from 0 -> Q steps 1..15,0,1; RCO=1 only while Q=15.
REQ-032 Ld_n=0, D=4'hE, EP=ET=1 one edge, then Ld_n=1 -> Q=14, then 15 (RCO=1), then 0 (RCO=0).
REQ-033 Q=7, EP=0 ET=1 three edges -> Q stays 7; EP=1 ET=0 -> Q stays 7; Q=15 ET=0 -> RCO=0.
REQ-034 Counting at Q=15 with Rn=0 on the wrap edge -> Q=0; two sync_cnt4 cascaded via RCO->ET, 256 edges -> 8-bit count wraps 255->0 once.
REQ-035 SYNC_CNT4_UPDN_EN build: Q=1, Up=0, EP=ET=1, three edges -> Q=0 (RCO=1), 15, 14; Up=1 next edge -> 15.
